// File: rtl/multi_mode_reduce_unit.sv
// Per-chain vector reduction (pass / sum / signed max / signed min; single or grouped; optional running accumulation).
// Latency: 2 cycles input to output, one vector per cycle, no bubbles for back-to-back accumulation.
// Backpressure: none; the unit always accepts and always emits, valid_out simply mirrors valid_in & tracing.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_in, vector_in        input vector (N lanes of DATA_WIDTH, lane 0 in the LSBs)
//   eof_in, bof_in, chainId_in frame sideband and owning chain; bof_in != 0 restarts accumulation
//   tracing                    1 = process vectors, 0 = configuration mode
//   configId, configData       configuration byte bus (one firmware byte per chain)
//   valid_out, vector_out,
//   eof_out, bof_out,
//   chainId_out                results and sideband, 2 cycles after their inputs
module multi_mode_reduce_unit #(
  parameter int                      N                  = 8,
  parameter int                      DATA_WIDTH         = 32,
  parameter int                      M                  = 2,
  parameter int                      MAX_CHAINS         = 4,
  parameter logic [7:0]              PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE   = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_in,
  input  logic [1:0]                      eof_in,
  input  logic [1:0]                      bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0]   chainId_in,
  input  logic                            tracing,
  input  logic [7:0]                      configId,
  input  logic [7:0]                      configData,
  input  logic [N*DATA_WIDTH-1:0]         vector_in,
  output logic                            valid_out,
  output logic [N*DATA_WIDTH-1:0]         vector_out,
  output logic [1:0]                      eof_out,
  output logic [1:0]                      bof_out,
  output logic [$clog2(MAX_CHAINS)-1:0]   chainId_out
);

  localparam int         CW     = $clog2(MAX_CHAINS);
  localparam int         GL     = N / M;            // lanes per group
  localparam logic [8:0] NCHAIN = 9'(MAX_CHAINS);

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  // op: 1 = wrapping sum, 2 = signed max, 3 = signed min; 0 never reaches a used result.
  function automatic data_t combine(input logic [1:0] op, input data_t a, input data_t b);
    data_t r;
    case (op)
      2'd1:    r = a + b;
      2'd2:    r = (a > b) ? a : b;
      2'd3:    r = (a < b) ? a : b;
      default: r = a;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Configuration: byte_counter walks the firmware table while this block is
  // addressed; any other configId rewinds it. Only op/grp/acc are kept, the
  // reserved upper nibble has no effect.
  // ---------------------------------------------------------------------------
  logic [3:0]    fw_q [MAX_CHAINS];
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic          cfg_hit, cfg_wr;
  logic [CW-1:0] cfg_idx;

  always_comb begin
    cfg_hit    = !tracing && (configId == PERSONAL_CONFIG_ID);
    cfg_wr     = cfg_hit && ({1'b0, byte_cnt_q} < NCHAIN);
    cfg_idx    = byte_cnt_q[CW-1:0];
    byte_cnt_d = byte_cnt_q;
    if (!tracing) begin
      if (cfg_hit) byte_cnt_d = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
      else         byte_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < MAX_CHAINS; c++) fw_q[c] <= INITIAL_FIRMWARE[c*8 +: 4];
      byte_cnt_q <= '0;
    end else begin
      if (cfg_wr) fw_q[cfg_idx] <= configData[3:0];
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: per-group partial reductions using the owning chain's firmware.
  // The raw vector is kept as well for pass-through mode.
  // ---------------------------------------------------------------------------
  logic [3:0] fw_sel;
  data_t      lane_in [N];
  data_t      part_d  [M];

  always_comb begin
    fw_sel = fw_q[chainId_in];
    for (int i = 0; i < N; i++) lane_in[i] = vector_in[i*DATA_WIDTH +: DATA_WIDTH];
    for (int g = 0; g < M; g++) begin
      data_t r;
      r = lane_in[g*GL];
      for (int j = 1; j < GL; j++) r = combine(fw_sel[1:0], r, lane_in[g*GL+j]);
      part_d[g] = r;
    end
  end

  logic                    s1_vld_q;
  logic [3:0]              s1_fw_q;
  logic [1:0]              s1_eof_q, s1_bof_q;
  logic [CW-1:0]           s1_chain_q;
  logic [N*DATA_WIDTH-1:0] s1_vec_q;
  data_t                   s1_part_q [M];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_fw_q    <= '0;
      s1_eof_q   <= '0;
      s1_bof_q   <= '0;
      s1_chain_q <= '0;
      s1_vec_q   <= '0;
      for (int g = 0; g < M; g++) s1_part_q[g] <= '0;
    end else begin
      s1_vld_q   <= valid_in & tracing;
      s1_fw_q    <= fw_sel;
      s1_eof_q   <= eof_in;
      s1_bof_q   <= bof_in;
      s1_chain_q <= chainId_in;
      s1_vec_q   <= vector_in;
      for (int g = 0; g < M; g++) s1_part_q[g] <= part_d[g];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: fold partials to the final result and update the accumulator.
  // Read-modify-write of the accumulator is entirely within this stage, so a
  // back-to-back vector of the same chain sees the value written one cycle ago.
  // ---------------------------------------------------------------------------
  data_t                   acc_q [MAX_CHAINS][M];
  logic [1:0]              s2_op;
  logic                    s2_grp, s2_acc, s2_wr;
  data_t                   red;
  data_t                   res_d [M];
  data_t                   acc_d [M];
  logic [N*DATA_WIDTH-1:0] vec_out_d;

  always_comb begin
    s2_op  = s1_fw_q[1:0];
    s2_grp = s1_fw_q[2];
    s2_acc = s1_fw_q[3];
    s2_wr  = s1_vld_q && (s2_op != 2'd0) && s2_acc;
    red    = s1_part_q[0];
    for (int g = 1; g < M; g++) red = combine(s2_op, red, s1_part_q[g]);
    for (int g = 0; g < M; g++) begin
      res_d[g] = s2_grp ? s1_part_q[g] : ((g == 0) ? red : '0);
      acc_d[g] = (s1_bof_q != 2'b00) ? res_d[g]
                                     : combine(s2_op, acc_q[s1_chain_q][g], res_d[g]);
    end
    vec_out_d = '0;
    if (s2_op == 2'd0) begin
      vec_out_d = s1_vec_q;
    end else begin
      for (int g = 0; g < M; g++)
        if (s2_grp || g == 0) vec_out_d[g*DATA_WIDTH +: DATA_WIDTH] = s2_acc ? acc_d[g] : res_d[g];
    end
  end

  // A firmware write clears its chain's accumulators; listed last so it wins
  // over an in-flight update to the same chain on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < MAX_CHAINS; c++)
        for (int g = 0; g < M; g++) acc_q[c][g] <= '0;
    end else begin
      if (s2_wr)
        for (int g = 0; g < M; g++)
          if (s2_grp || g == 0) acc_q[s1_chain_q][g] <= acc_d[g];
      if (cfg_wr)
        for (int g = 0; g < M; g++) acc_q[cfg_idx][g] <= '0;
    end
  end

  logic                    valid_out_q;
  logic [N*DATA_WIDTH-1:0] vector_out_q;
  logic [1:0]              eof_out_q, bof_out_q;
  logic [CW-1:0]           chain_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out_q  <= 1'b0;
      vector_out_q <= '0;
      eof_out_q    <= '0;
      bof_out_q    <= '0;
      chain_out_q  <= '0;
    end else begin
      valid_out_q  <= s1_vld_q;
      vector_out_q <= vec_out_d;
      eof_out_q    <= s1_eof_q;
      bof_out_q    <= s1_bof_q;
      chain_out_q  <= s1_chain_q;
    end
  end

  assign valid_out   = valid_out_q;
  assign vector_out  = vector_out_q;
  assign eof_out     = eof_out_q;
  assign bof_out     = bof_out_q;
  assign chainId_out = chain_out_q;

endmodule

// File: tb/tb_multi_mode_reduce_unit.sv
// Scoreboard bench for multi_mode_reduce_unit: directed vectors with hand-computed results.
// Latency: expects each valid result exactly 2 cycles after its input.
// Backpressure: none; any unexpected valid_out is reported.
module tb_multi_mode_reduce_unit;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_in;
  logic [1:0]      eof_in, bof_in;
  logic [CW-1:0]   chainId_in;
  logic            tracing;
  logic [7:0]      configId, configData;
  logic [N*DW-1:0] vector_in;
  logic            valid_out;
  logic [N*DW-1:0] vector_out;
  logic [1:0]      eof_out, bof_out;
  logic [CW-1:0]   chainId_out;

  multi_mode_reduce_unit dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .eof_in(eof_in), .bof_in(bof_in),
    .chainId_in(chainId_in), .tracing(tracing), .configId(configId), .configData(configData),
    .vector_in(vector_in), .valid_out(valid_out), .vector_out(vector_out),
    .eof_out(eof_out), .bof_out(bof_out), .chainId_out(chainId_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              id;
    logic [N*DW-1:0] vec;
    logic [1:0]      eof;
    logic [1:0]      bof;
    logic [CW-1:0]   ch;
    int              cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   next_id = 0;

  function automatic logic [N*DW-1:0] mk(input int a0, input int a1, input int a2, input int a3,
                                         input int a4, input int a5, input int a6, input int a7);
    return {32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [N*DW-1:0] r1(input int a);
    return mk(a, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [N*DW-1:0] r2(input int a, input int b);
    return mk(a, b, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [N*DW-1:0] fill(input logic [31:0] x);
    return {N{x}};
  endfunction

  // One vector per call; successive calls are back-to-back.
  task automatic drive(input logic [N*DW-1:0] v, input logic [CW-1:0] ch, input logic [1:0] bof,
                       input logic [1:0] eof, input bit expect_out, input logic [N*DW-1:0] expv);
    exp_t e;
    @(posedge clk); #1;
    valid_in = 1'b1; tracing = 1'b1; vector_in = v; chainId_in = ch; bof_in = bof; eof_in = eof;
    if (expect_out) begin
      e.id = next_id; e.vec = expv; e.eof = eof; e.bof = bof; e.ch = ch; e.cyc = cyc + 2;
      next_id++;
      q.push_back(e);
    end
  endtask

  // valid_in stays high so that tracing=0 must suppress valid_out.
  task automatic cfg_byte(input logic [7:0] id, input logic [7:0] data);
    @(posedge clk); #1;
    valid_in = 1'b1; tracing = 1'b0; configId = id; configData = data;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0; tracing = 1'b1;
    end
  endtask

  // Monitor: every valid output must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_out) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output cyc=%0d got vec=%h", cyc, vector_out);
        end else begin
          e = q.pop_front();
          if (vector_out !== e.vec || eof_out !== e.eof || bof_out !== e.bof ||
              chainId_out !== e.ch || cyc != e.cyc) begin
            failures++;
            $display("FAIL result_%0d got vec=%h eof=%0d bof=%0d ch=%0d cyc=%0d expected vec=%h eof=%0d bof=%0d ch=%0d cyc=%0d",
                     e.id, vector_out, eof_out, bof_out, chainId_out, cyc,
                     e.vec, e.eof, e.bof, e.ch, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  localparam logic [N*DW-1:0] SEQ = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};

  initial begin
    logic [N*DW-1:0] mm;
    mm = mk(-5, 3, 7, -1, 0, 2, 6, -8);
    rst_n = 1'b0; valid_in = 1'b0; tracing = 1'b1; eof_in = '0; bof_in = '0; chainId_in = '0;
    configId = 8'hFF; configData = '0; vector_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-stream: first vector is on the outputs, second in flight; both lost.
    drive(SEQ, 2'd1, 2'b11, 2'b11, 1'b0, '0);
    drive(fill(32'd9), 2'd2, 2'b01, 2'b01, 1'b0, '0);
    @(posedge clk); #1;
    rst_n = 1'b0; valid_in = 1'b0;
    #1;
    checks++;
    if ({valid_out, vector_out, eof_out, bof_out, chainId_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%0b vec=%h eof=%0d bof=%0d ch=%0d expected all zero",
               valid_out, vector_out, eof_out, bof_out, chainId_out);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // Pass-through with reset firmware.
    drive(SEQ, 2'd0, 2'b00, 2'b01, 1'b1, SEQ);
    idle(4);

    // Configuration; sideband must still flow with valid_out low.
    eof_in = 2'b10; bof_in = 2'b01; chainId_in = 2'd3;
    cfg_byte(8'hFF, 8'h00);
    cfg_byte(8'h00, 8'h01);
    cfg_byte(8'h00, 8'h05);
    cfg_byte(8'h00, 8'h02);
    cfg_byte(8'h00, 8'h07);
    cfg_byte(8'h00, 8'h0F);
    cfg_byte(8'h00, 8'h0F);
    @(negedge clk);
    checks++;
    if ({valid_out, eof_out, bof_out, chainId_out} !== {1'b0, 2'b10, 2'b01, 2'd3}) begin
      failures++;
      $display("FAIL sideband_idle got valid=%0b eof=%0d bof=%0d ch=%0d expected valid=0 eof=2 bof=1 ch=3",
               valid_out, eof_out, bof_out, chainId_out);
    end

    drive(SEQ, 2'd0, 2'b00, 2'b00, 1'b1, r1(36));
    drive(SEQ, 2'd1, 2'b00, 2'b00, 1'b1, r2(10, 26));
    drive(mm,  2'd2, 2'b00, 2'b01, 1'b1, r1(7));
    drive(mm,  2'd3, 2'b00, 2'b10, 1'b1, r2(-5, -8));
    idle(4);

    // Accumulation: chain 0 = sum/single/acc, chain 1 = sum/group/acc.
    cfg_byte(8'hFF, 8'h00);
    cfg_byte(8'h00, 8'h09);
    cfg_byte(8'h00, 8'h0D);
    drive(fill(32'd1), 2'd0, 2'b01, 2'b00, 1'b1, r1(8));
    drive(fill(32'd2), 2'd0, 2'b00, 2'b00, 1'b1, r1(24));
    drive(fill(32'd1), 2'd0, 2'b01, 2'b00, 1'b1, r1(8));
    drive(fill(32'd1), 2'd0, 2'b01, 2'b00, 1'b1, r1(8));
    drive(SEQ,         2'd1, 2'b01, 2'b00, 1'b1, r2(10, 26));
    drive(fill(32'd2), 2'd0, 2'b00, 2'b00, 1'b1, r1(24));
    drive(SEQ,         2'd1, 2'b10, 2'b00, 1'b1, r2(10, 26));
    drive(fill(32'd1), 2'd0, 2'b01, 2'b00, 1'b1, r1(8));

    // Wrapping sums.
    drive(fill(32'h8000_0000), 2'd0, 2'b01, 2'b00, 1'b1, r1(0));
    drive(fill(32'hFFFF_FFFF), 2'd0, 2'b01, 2'b00, 1'b1, r1(32'hFFFF_FFF8));

    // Mid-flight reconfiguration: acc holds -8, in-flight sum gives -8 + 24 = 16.
    drive(fill(32'd3), 2'd0, 2'b00, 2'b00, 1'b1, r1(16));
    cfg_byte(8'hFF, 8'h00);
    cfg_byte(8'h00, 8'h0A);
    // New mode max/acc on a cleared accumulator: max(0, 8) = 8.
    drive(SEQ, 2'd0, 2'b00, 2'b00, 1'b1, r1(8));
    idle(6);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_outputs got pending=%0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
